int_bound_solver: RTL and testbench
===================================

// Module: int_bound_solver
// PURPOSE
// Inverse of the clause checker: given two linear integer clauses a0*y0 + a1*y1 + c <= 0 and the current
// assignment, computes the interval [lower, upper] of values of a selected variable y_k that satisfies
// both clauses with the other variable held fixed. Feeds the MCMC proposal stage; multi-cycle, serial divider.
// PARAMETERS
// WIDTH     `BIT_WIDTH_OF_INTEGER_VARIABLE  signed width of coefficients, constant, assignments, bounds
// NUM_VARS  `NUMBER_OF_INTEGER_VARIABLES    integer variables per clause (fixed 2; packing below assumes 2)
// RW        2*WIDTH+2 (localparam)          residual/divider width; also divider iteration count
// PORTS
// in_clk                   in   1              clock, all state on rising edge
// in_reset                 in   1              synchronous, active-high reset
// in_enable                in   1              0 = FSM and datapath frozen (all regs hold)
// in_start                 in   1              request pulse; accepted only in IDLE with in_enable=1
// in_var_select            in   1              k: variable to bound (0 = y0, 1 = y1)
// in_coefficients_clause1  in   3*WIDTH        {c, a1, a0}, each signed WIDTH
// in_coefficients_clause2  in   3*WIDTH        {c, a1, a0}
// in_current_assignment    in   2*WIDTH        {y1, y0}, signed
// out_lower / out_upper    out  WIDTH          signed bounds on y_k, valid when out_done, held until next done
// out_feasible             out  1              1 = interval non-empty and no zero-coeff clause violated
// out_done                 out  1              one-cycle pulse when results update
// out_busy                 out  1              1 from cycle after accept until done cycle inclusive
// BEHAVIOUR
// - Reset: FSM->IDLE; out_lower=out_upper=0, out_feasible=0, out_done=0, out_busy=0.
// - Accept: all inputs registered on the accepting edge; later input changes have no effect. in_start while busy ignored.
// - FSM: IDLE -start-> RESID(i=0) -> DIV (RW cycles) -> MERGE -> (i=0: RESID(i=1)) | (i=1: DONE) -> IDLE.
//   RESID: R = -(a_j*y_j + c), j != k, computed in RW signed bits (no overflow possible).
//   DIV: restoring divide |R| / |a_k|, 1 quotient bit/cycle, RW cycles; runs even if a_k==0 (fixed latency).
//   MERGE: a_k>0: upper_i = floor(R/a_k); a_k<0: lower_i = ceil(R/a_k); a_k==0: no bound, and R<0 sets infeasible flag.
//   Rounding from q,rem: a>0: R>=0 -> q, R<0 -> -(q+(rem!=0)); a<0: R<=0 -> q+(rem!=0), R>0 -> -q.
//   Each bound saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1] before merge.
//   Running bounds init to lower=-2^(WIDTH-1), upper=2^(WIDTH-1)-1 on accept; merge: lower=max, upper=min.
//   DONE: outputs registered, out_done=1 one cycle, out_feasible = (lower<=upper) && !infeasible flag.
// - Latency: start accepted at edge t -> out_done high in cycle t+2*RW+5 (t+41 for WIDTH=8), independent of data.
// - in_enable=0 mid-operation stretches latency by the frozen cycles; out_done pulse frozen high if frozen in DONE.
// - in_reset mid-operation: abort, outputs to reset values next cycle; no done pulse for the aborted request.
// - Back-to-back: start may be accepted in the cycle after DONE (IDLE).
// CONFIGURATION
// IGNORE_CLAUSE_EN defined: adds port in_clause_active (in, 2): bit i=0 -> clause i+1 contributes no bound and
//   cannot set infeasible; still takes its RW+2 cycles. Sampled on accept.
// Undefined: port absent, both clauses always active.
// TESTING (WIDTH=8, clause tuples {c,a1,a0})
// 1 k=0, y1=4, cl1 {-10,1,2}, cl2 {1,0,-1} -> lower=1, upper=3, feasible=1, done exactly 41 cycles after start.
// 2 k=0, cl1 {-7,0,3}, cl2 {-7,0,-3} -> upper=floor(7/3)=2, lower=ceil(-7/3)=-2, feasible=1.
// 3 k=1, y0=3, cl1 {5,0,1} (a1=0, R=-8), cl2 {0,0,0} -> feasible=0; lower=-128, upper=127.
// 4 k=0, y1=-128, cl1 {0,-128,1} (y0<=-16384), cl2 {0,0,0} -> upper saturates -128, lower=-128, feasible=1.
// 5 reset at cycle 10 of DIV -> next cycle busy=0, all outputs 0, no done; start pulses while busy ignored.
// 6 IGNORE_CLAUSE_EN, test 1 with in_clause_active=2'b01 -> lower=-128, upper=3, feasible=1.

Source files
------------

// File: rtl/int_bound_solver.sv
// Bounds one integer variable of a two-clause linear system (a0*y0 + a1*y1 + c <= 0) with the other held fixed.
// Optional IGNORE_CLAUSE_EN adds in_clause_active to mask individual clauses.
module int_bound_solver #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned NUM_VARS = 2
) (
    input  logic                        in_clk,
    input  logic                        in_reset,
    input  logic                        in_enable,
    input  logic                        in_start,
    input  logic                        in_var_select,
    input  logic [3*WIDTH-1:0]          in_coefficients_clause1,
    input  logic [3*WIDTH-1:0]          in_coefficients_clause2,
    input  logic [NUM_VARS*WIDTH-1:0]   in_current_assignment,
`ifdef IGNORE_CLAUSE_EN
    input  logic [1:0]                  in_clause_active,
`endif
    output logic signed [WIDTH-1:0]     out_lower,
    output logic signed [WIDTH-1:0]     out_upper,
    output logic                        out_feasible,
    output logic                        out_done,
    output logic                        out_busy
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned RW = 2 * WIDTH + 2;
    localparam int unsigned CW = $clog2(RW);
    localparam logic signed [W-1:0]  S_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  S_MIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [RW-1:0] SAT_HI = RW'(S_MAX);
    localparam logic signed [RW-1:0] SAT_LO = RW'(S_MIN);

    typedef enum logic [2:0] {S_IDLE, S_RESID, S_DIV, S_MERGE, S_DONE} state_t;

    state_t state, state_nx;

    logic                        k_r;
    logic [3*W-1:0]              cl1_r, cl2_r;
    logic [NUM_VARS*W-1:0]       y_r;
    logic [1:0]                  act_r;
    logic                        clause_r;
    logic signed [W-1:0]         lo_r, up_r;
    logic                        inf_r;
    logic signed [RW-1:0]        resid_r;
    logic [RW-1:0]               quo_r, rem_r;
    logic [CW-1:0]               cnt_r;

    logic [1:0]                  clause_active_c;
`ifdef IGNORE_CLAUSE_EN
    assign clause_active_c = in_clause_active;
`else
    assign clause_active_c = 2'b11;
`endif

    // Operand selection for the clause currently being processed
    logic [3*W-1:0]       cl_sel_c;
    logic signed [W-1:0]  a0_c, a1_c, c_c, y0_c, y1_c, ak_c, aj_c, yj_c;
    logic signed [RW-1:0] aj_x_c, yj_x_c, c_x_c, resid_c;
    logic [RW-1:0]        resid_abs_c;
    logic [W-1:0]         ak_abs_c;
    logic [RW-1:0]        trial_c;
    logic                 fits_c;

    always_comb begin
        cl_sel_c    = clause_r ? cl2_r : cl1_r;
        a0_c        = cl_sel_c[W-1:0];
        a1_c        = cl_sel_c[2*W-1:W];
        c_c         = cl_sel_c[3*W-1:2*W];
        y0_c        = y_r[W-1:0];
        y1_c        = y_r[2*W-1:W];
        ak_c        = k_r ? a1_c : a0_c;
        aj_c        = k_r ? a0_c : a1_c;
        yj_c        = k_r ? y0_c : y1_c;
        aj_x_c      = RW'(aj_c);
        yj_x_c      = RW'(yj_c);
        c_x_c       = RW'(c_c);
        resid_c     = -((aj_x_c * yj_x_c) + c_x_c);
        resid_abs_c = resid_c[RW-1] ? RW'(-resid_c) : RW'(resid_c);
        ak_abs_c    = ak_c[W-1] ? W'(-ak_c) : W'(ak_c);
        trial_c     = {rem_r[RW-2:0], quo_r[RW-1]};
        fits_c      = (trial_c >= RW'(ak_abs_c));
    end

    // Signed floor/ceil from the unsigned quotient, saturation and merge
    logic signed [RW-1:0] q_s_c, rnz_c, bnd_full_c;
    logic signed [W-1:0]  bnd_sat_c, lo_nx_c, up_nx_c;
    logic                 apply_c, inf_nx_c;

    always_comb begin
        q_s_c   = $signed(quo_r);
        rnz_c   = {{(RW-1){1'b0}}, |rem_r};
        if (!ak_c[W-1])
            bnd_full_c = !resid_r[RW-1] ? q_s_c : -(q_s_c + rnz_c);
        else
            bnd_full_c = (resid_r[RW-1] || (resid_r == '0)) ? (q_s_c + rnz_c) : -q_s_c;
        if (bnd_full_c > SAT_HI)
            bnd_sat_c = S_MAX;
        else if (bnd_full_c < SAT_LO)
            bnd_sat_c = S_MIN;
        else
            bnd_sat_c = W'(bnd_full_c);
        apply_c  = act_r[clause_r] && (ak_c != '0);
        lo_nx_c  = (apply_c && ak_c[W-1] && (bnd_sat_c > lo_r)) ? bnd_sat_c : lo_r;
        up_nx_c  = (apply_c && !ak_c[W-1] && (bnd_sat_c < up_r)) ? bnd_sat_c : up_r;
        inf_nx_c = inf_r | (act_r[clause_r] && (ak_c == '0) && resid_r[RW-1]);
    end

    always_ff @(posedge in_clk) begin
        if (in_reset)
            state <= S_IDLE;
        else if (in_enable)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_start) state_nx = S_RESID;
            S_RESID: state_nx = S_DIV;
            S_DIV:   if (cnt_r == CW'(RW - 1)) state_nx = S_MERGE;
            S_MERGE: state_nx = clause_r ? S_DONE : S_RESID;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            k_r          <= 1'b0;
            cl1_r        <= '0;
            cl2_r        <= '0;
            y_r          <= '0;
            act_r        <= '0;
            clause_r     <= 1'b0;
            lo_r         <= '0;
            up_r         <= '0;
            inf_r        <= 1'b0;
            resid_r      <= '0;
            quo_r        <= '0;
            rem_r        <= '0;
            cnt_r        <= '0;
            out_lower    <= '0;
            out_upper    <= '0;
            out_feasible <= 1'b0;
            out_done     <= 1'b0;
            out_busy     <= 1'b0;
        end else if (in_enable) begin
            case (state)
                S_IDLE: begin
                    out_done <= 1'b0;
                    if (in_start) begin
                        k_r      <= in_var_select;
                        cl1_r    <= in_coefficients_clause1;
                        cl2_r    <= in_coefficients_clause2;
                        y_r      <= in_current_assignment;
                        act_r    <= clause_active_c;
                        clause_r <= 1'b0;
                        lo_r     <= S_MIN;
                        up_r     <= S_MAX;
                        inf_r    <= 1'b0;
                        out_busy <= 1'b1;
                    end
                end
                S_RESID: begin
                    resid_r <= resid_c;
                    quo_r   <= resid_abs_c;
                    rem_r   <= '0;
                    cnt_r   <= '0;
                end
                // Restoring divide; quo_r shifts the dividend out and the quotient in
                S_DIV: begin
                    rem_r <= fits_c ? (trial_c - RW'(ak_abs_c)) : trial_c;
                    quo_r <= {quo_r[RW-2:0], fits_c};
                    cnt_r <= cnt_r + CW'(1);
                end
                S_MERGE: begin
                    lo_r     <= lo_nx_c;
                    up_r     <= up_nx_c;
                    inf_r    <= inf_nx_c;
                    clause_r <= 1'b1;
                    if (clause_r) begin
                        out_lower    <= lo_nx_c;
                        out_upper    <= up_nx_c;
                        out_feasible <= (lo_nx_c <= up_nx_c) && !inf_nx_c;
                        out_done     <= 1'b1;
                    end
                end
                S_DONE: begin
                    out_done <= 1'b0;
                    out_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_bound_solver.sv
// Self-checking bench for int_bound_solver: directed vector table, multi-cycle corner sequences and
// randomized requests against an integer-arithmetic reference model.
module tb_int_bound_solver;

    localparam int unsigned W   = 8;
    localparam int unsigned RW  = 2 * W + 2;
    // done is seen after this many edges following the accepting edge (41st cycle counting the start cycle)
    localparam int          LAT = 2 * RW + 4;

    typedef struct {
        logic           k;
        logic [3*W-1:0] c1;
        logic [3*W-1:0] c2;
        logic [2*W-1:0] y;
        logic [1:0]     act;
        int             lo;
        int             up;
        bit             feas;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b1;
    logic                start = 1'b0;
    logic                vsel = 1'b0;
    logic [3*W-1:0]      cl1 = '0;
    logic [3*W-1:0]      cl2 = '0;
    logic [2*W-1:0]      asg = '0;
    logic [1:0]          act = 2'b11;
    logic signed [W-1:0] lower, upper;
    logic                feasible, done, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    int_bound_solver #(.WIDTH(W), .NUM_VARS(2)) dut (
        .in_clk                  (clk),
        .in_reset                (rst),
        .in_enable               (en),
        .in_start                (start),
        .in_var_select           (vsel),
        .in_coefficients_clause1 (cl1),
        .in_coefficients_clause2 (cl2),
        .in_current_assignment   (asg),
`ifdef IGNORE_CLAUSE_EN
        .in_clause_active        (act),
`endif
        .out_lower               (lower),
        .out_upper               (upper),
        .out_feasible            (feasible),
        .out_done                (done),
        .out_busy                (busy)
    );

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [3*W-1:0] cl(input int c, input int a1, input int a0);
        return {W'(c), W'(a1), W'(a0)};
    endfunction

    function automatic logic [2*W-1:0] yy(input int y1, input int y0);
        return {W'(y1), W'(y0)};
    endfunction

    function automatic vec_t mk(input logic k, input logic [3*W-1:0] c1, input logic [3*W-1:0] c2,
                                input logic [2*W-1:0] y, input logic [1:0] a,
                                input int lo, input int up, input bit feas);
        vec_t v;
        v.k = k; v.c1 = c1; v.c2 = c2; v.y = y; v.act = a;
        v.lo = lo; v.up = up; v.feas = feas;
        return v;
    endfunction

    function automatic int floor_div(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d != 0) && ((n < 0) != (d < 0))) q = q - 1;
        return q;
    endfunction

    function automatic int ceil_div(input int n, input int d);
        int q;
        q = n / d;
        if ((n % d != 0) && ((n < 0) == (d < 0))) q = q + 1;
        return q;
    endfunction

    function automatic int sat(input int x);
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    // Reference: intersect the solution sets of a_k*y_k <= -(a_j*y_j + c) for each active clause
    function automatic void model(input vec_t v, output int lo, output int up, output bit feas);
        logic [3*W-1:0] c;
        int a0, a1, cc, y0, y1, ak, r;
        bit inf;
        lo = -128; up = 127; inf = 0;
        y0 = $signed(v.y[W-1:0]);
        y1 = $signed(v.y[2*W-1:W]);
        for (int i = 0; i < 2; i++) begin
            c  = (i == 0) ? v.c1 : v.c2;
            a0 = $signed(c[W-1:0]);
            a1 = $signed(c[2*W-1:W]);
            cc = $signed(c[3*W-1:2*W]);
            ak = v.k ? a1 : a0;
            r  = v.k ? -(a0 * y0 + cc) : -(a1 * y1 + cc);
            if (v.act[i]) begin
                if (ak == 0) begin
                    if (r < 0) inf = 1;
                end else if (ak > 0) begin
                    if (sat(floor_div(r, ak)) < up) up = sat(floor_div(r, ak));
                end else begin
                    if (sat(ceil_div(r, ak)) > lo) lo = sat(ceil_div(r, ak));
                end
            end
        end
        feas = (lo <= up) && !inf;
    endfunction

    function automatic int rnd_val();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return -128;
        if (r == 2) return 127;
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic scramble();
        cl1  = (3*W)'($urandom);
        cl2  = (3*W)'($urandom);
        asg  = (2*W)'($urandom);
        vsel = 1'($urandom);
        act  = 2'($urandom);
    endtask

    // Issue one request; optional enable freeze window and a stray start pulse while busy
    task automatic run_req(input vec_t v, input int frz_at, input int frz_len,
                           output int lo, output int up, output bit feas, output int lat);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1; n++;
        end
        vsel = v.k; cl1 = v.c1; cl2 = v.c2; asg = v.y; act = v.act; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        n = 0;
        while (!done && n < 200) begin
            if (n == 3) start = 1'b1;
            if (n == 4) start = 1'b0;
            if (n == frz_at) en = 1'b0;
            if (n == frz_at + frz_len) en = 1'b1;
            @(posedge clk); #1; n++;
        end
        en = 1'b1; start = 1'b0;
        lo = int'(lower); up = int'(upper); feas = feasible; lat = n;
    endtask

    task automatic run_and_check(input string tag, input vec_t v, input int frz_len);
        int lo, up, lat;
        bit feas;
        run_req(v, (frz_len > 0) ? 5 : -1, frz_len, lo, up, feas, lat);
        check({tag, ".lower"}, lo, v.lo);
        check({tag, ".upper"}, up, v.up);
        check({tag, ".feasible"}, int'(feas), int'(v.feas));
        check({tag, ".latency"}, lat, LAT + frz_len);
    endtask

    vec_t vq[$];

    initial begin
        vec_t v;
        int lo, up, cnt;
        bit feas;

        vq.push_back(mk(1'b0, cl(-10, 1, 2),     cl(1, 0, -1),    yy(4, 0),    2'b11,    1,    3, 1'b1));
        vq.push_back(mk(1'b0, cl(-7, 0, 3),      cl(-7, 0, -3),   yy(0, 0),    2'b11,   -2,    2, 1'b1));
        vq.push_back(mk(1'b1, cl(5, 0, 1),       cl(0, 0, 0),     yy(0, 3),    2'b11, -128,  127, 1'b0));
        vq.push_back(mk(1'b0, cl(0, -128, 1),    cl(0, 0, 0),     yy(-128, 0), 2'b11, -128, -128, 1'b1));
        vq.push_back(mk(1'b0, cl(0, 0, -128),    cl(-127, 0, 127), yy(5, 0),   2'b11,    0,    1, 1'b1));
        vq.push_back(mk(1'b1, cl(0, 1, -1),      cl(5, -1, 0),    yy(0, 2),    2'b11,    5,    2, 1'b0));
        vq.push_back(mk(1'b0, cl(7, 0, 2),       cl(-7, 0, -2),   yy(0, 0),    2'b11,   -3,   -4, 1'b0));
`ifdef IGNORE_CLAUSE_EN
        vq.push_back(mk(1'b0, cl(-10, 1, 2),     cl(1, 0, -1),    yy(4, 0),    2'b01, -128,    3, 1'b1));
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset.lower", int'(lower), 0);
        check("reset.upper", int'(upper), 0);
        check("reset.feasible", int'(feasible), 0);
        check("reset.done", int'(done), 0);
        check("reset.busy", int'(busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vq[i]) run_and_check($sformatf("vec%0d", i), vq[i], 0);

        // Enable freeze mid-operation stretches latency
        run_and_check("freeze", vq[0], 7);

        // Freeze while in DONE holds the pulse
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_hold.done", int'(done), 1);
        check("done_hold.busy", int'(busy), 1);
        en = 1'b1;
        @(posedge clk); #1;
        check("done_release.done", int'(done), 0);
        check("done_release.busy", int'(busy), 0);

        // Reset partway through DIV aborts the request
        vsel = vq[0].k; cl1 = vq[0].c1; cl2 = vq[0].c2; asg = vq[0].y; act = vq[0].act;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
            start = ~start;
        end
        start = 1'b0;
        check("abort.busy_before", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort.busy", int'(busy), 0);
        check("abort.done", int'(done), 0);
        check("abort.lower", int'(lower), 0);
        check("abort.upper", int'(upper), 0);
        check("abort.feasible", int'(feasible), 0);
        rst = 1'b0;
        cnt = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done) cnt++;
        end
        check("abort.no_done", cnt, 0);
        run_and_check("after_abort", vq[1], 0);

        // Randomized requests, back-to-back, against the reference model
        for (int i = 0; i < 40; i++) begin
            v.k  = 1'($urandom);
            v.c1 = cl(rnd_val(), rnd_val(), rnd_val());
            v.c2 = cl(rnd_val(), rnd_val(), rnd_val());
            v.y  = yy(rnd_val(), rnd_val());
`ifdef IGNORE_CLAUSE_EN
            v.act = 2'($urandom);
`else
            v.act = 2'b11;
`endif
            model(v, lo, up, feas);
            v.lo = lo; v.up = up; v.feas = feas;
            run_and_check($sformatf("rand%0d", i), v, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
